gain_ramp: RTL and testbench
============================

# gain_ramp

Multichannel fixed-point gain stage for the pedal's sample path: applies one signed gain to time-multiplexed CH-channel AXI-Stream frames. The gain is ramped toward the programmed target once per frame, which removes zipper noise. Output is rounded and optionally saturated. It replaces the single-channel gain stage between the effect chain and the output mixer.

## Interface
- DW, 24: sample width, signed two's complement.
- COEFW, 18: gain width, signed.
- COEFQ, 16: gain fractional bits; unity is 2^COEFQ.
- CH, 2: channels per frame, ≥1.
- STEPW, 12: ramp step width, unsigned.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  DW  input sample, signed.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; registered.
- s_axis_tlast  in  1  marks the last channel of a frame.
- m_axis_tdata  out  DW  scaled sample, signed.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  tlast carried alongside the sample.
- k_target  in  COEFW  target gain, signed Q(COEFW-COEFQ).COEFQ; quasi-static.
- k_step  in  STEPW  ramp increment per frame; 0 means jump to target.
- k_current  out  COEFW  gain currently applied.
- ramping  out  1  high while k_current ≠ registered target.
- frame_err  out  1  one-cycle pulse on a framing violation.

## Operation
- Input path:
  - 2-entry skid buffer drives s_axis_tready from a register.
  - Full throughput; no combinational path from m_axis_tready to s_axis_tready.
- Pipeline:
  - Stage M registers product = k_current × sample (DW+COEFW bits) plus tlast.
  - Stage O registers the rounded/limited result.
  - Both stages advance when their successor is empty or being drained (standard valid/ready stage rules).
- Gain applies per frame:
  - All beats of one frame use the same k_current.
  - k_current updates in the cycle the tlast beat enters stage M.
- Ramp update (registered target kt = k_target sampled at the same edge):
  - If k_step = 0 or |kt − k_current| ≤ k_step, then k_current ← kt.
  - Otherwise k_current ← k_current ± k_step, toward kt.
  - Arithmetic is COEFW+1 bits; no overshoot and no wrap.
- Rounding: add 2^(COEFQ−1), then take bits [COEFQ+DW−1+1 : COEFQ] for the limit check. This is round-half-up.
- Channel counter:
  - 0..CH−1; increments per beat entering stage M.
  - Clears on tlast.
  - frame_err pulses if tlast arrives with count ≠ CH−1, or count = CH−1 without tlast.
  - On error, the counter resyncs to 0 on the next tlast. Data passes unmodified.
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, s_axis_tready 0 while rst is asserted and 1 the cycle after, k_current 0, ramping 0, frame_err 0, counter 0. The design fades in from silence.
- Reset mid-frame:
  - In-flight beats are discarded.
  - Counter returns to 0; upstream restarts at channel 0.

## Timing
- Latency: beat accepted at edge n appears with m_axis_tvalid at edge n+2, given no backpressure.
- Throughput: 1 beat/cycle sustained with m_axis_tready held high.
- Backpressure:
  - m_axis_tdata, tlast and tvalid hold stable while tvalid=1 and tready=0.
  - Up to 4 beats are absorbed (skid 2 + M + O) before s_axis_tready drops, no earlier than 1 cycle after stall.
- Ramp duration from k_current a to target b: ceil(|b−a| / k_step) frames.
- k_target change takes effect at the next tlast entering stage M, never mid-frame.

## Configuration
- GAIN_SAT_EN defined:
  - Rounded result clamps to [−2^(DW−1), 2^(DW−1)−1].
  - Adds a sticky output sat_flag (1 bit), cleared by rst only.
- GAIN_SAT_EN undefined:
  - Result is the low DW bits of the rounded value, i.e. two's-complement wrap.
  - sat_flag is absent.

## Test plan
- Reset release, DW=24, COEFQ=16, CH=2, k_target=0x10000, k_step=0x4000; continuous frames of 0x100000 → first frame outputs 0; later frames 0x040000, 0x080000, 0x0C0000, then 0x100000 steady; ramping falls with the 4th update.
- k_step=0, k_target=0x08000 (0.5): input 3 → output 2 (1.5 rounds up); input −3 → −1.
- GAIN_SAT_EN, k=0x20000 (2.0), input 0x500000 → 0x7FFFFF, sat_flag=1; without GAIN_SAT_EN → 0xA00000.
- Random m_axis_tready at 50 %, 1000 beats → output sequence identical to the no-stall run; no beat lost or duplicated; data stable while stalled.
- tlast on beat 0 of a CH=2 frame → frame_err one pulse; next correct frame → no error; k_current updates on every tlast.
- rst asserted mid-ramp with output stalled → m_axis_tvalid=0 and k_current=0 immediately; normal flow resumes 1 cycle after release.

Source files
------------

// File: rtl/gain_ramp.sv
// gain_ramp: per-frame ramped signed gain on time-multiplexed AXI-Stream channels, 2-cycle latency.
// Registered-ready 2-entry skid feeds stage M (product) and stage O (round/limit); GAIN_SAT_EN enables clamping and sat_flag.
module gain_ramp #(
  parameter int DW    = 24,
  parameter int COEFW = 18,
  parameter int COEFQ = 16,
  parameter int CH    = 2,
  parameter int STEPW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DW-1:0]     m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic [COEFW-1:0]  k_target,
  input  logic [STEPW-1:0]  k_step,
  output logic [COEFW-1:0]  k_current,
  output logic              ramping,
`ifdef GAIN_SAT_EN
  output logic              sat_flag,
`endif
  output logic              frame_err
);

  localparam int PW = DW + COEFW;
  localparam int AW = (COEFW >= STEPW) ? COEFW + 1 : STEPW + 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  // skid buffer state
  logic [DW:0]     sk_mem_q [2];
  logic [DW:0]     sk_mem_d [2];
  logic            sk_wp_q, sk_wp_d, sk_rp_q, sk_rp_d;
  logic [1:0]      sk_cnt_q, sk_cnt_d;
  logic            sk_rdy_q, sk_rdy_d;
  logic            sk_push, sk_pop, sk_vld;
  logic [DW:0]     sk_head;

  // pipeline state
  logic            m_vld_q, m_vld_d, m_last_q, m_last_d;
  logic [PW-1:0]   m_prod_q, m_prod_d;
  logic            o_vld_q, o_vld_d, o_last_q, o_last_d;
  logic [DW-1:0]   o_dat_q, o_dat_d;
  logic            o_adv, m_adv, o_load;

  // gain and framing state
  logic [COEFW-1:0] kc_q, kc_d, kt_q, kt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic signed [PW-1:0] prod_w;
  logic [PW-1:0]        rnd_w;
  logic [DW-1:0]        res_w;
  logic [AW-1:0]        kt_x, kc_x, st_x, diff_w, adiff_w, nxt_w;

`ifdef GAIN_SAT_EN
  logic [DW:0]     rsel_w;
  logic            ovf_w;
  logic            sat_q, sat_d;
`endif

  always_comb begin
    o_adv   = !o_vld_q || m_axis_tready;
    m_adv   = !m_vld_q || o_adv;
    sk_vld  = (sk_cnt_q != 2'd0);
    sk_head = sk_mem_q[sk_rp_q];
    sk_push = s_axis_tvalid && sk_rdy_q;
    sk_pop  = sk_vld && m_adv;
    o_load  = m_vld_q && o_adv;
  end

  always_comb begin
    sk_mem_d = sk_mem_q;
    if (sk_push) sk_mem_d[sk_wp_q] = {s_axis_tlast, s_axis_tdata};
    sk_wp_d  = sk_wp_q ^ sk_push;
    sk_rp_d  = sk_rp_q ^ sk_pop;
    sk_cnt_d = sk_cnt_q + {1'b0, sk_push} - {1'b0, sk_pop};
    // ready looks at next occupancy so it can be a flop without losing throughput
    sk_rdy_d = (sk_cnt_d != 2'd2);
  end

  always_comb begin
    prod_w = $signed({{DW{kc_q[COEFW-1]}}, kc_q}) *
             $signed({{COEFW{sk_head[DW-1]}}, sk_head[DW-1:0]});
    m_vld_d  = m_adv ? sk_vld : m_vld_q;
    m_prod_d = sk_pop ? prod_w : m_prod_q;
    m_last_d = sk_pop ? sk_head[DW] : m_last_q;
  end

  always_comb begin
    rnd_w = m_prod_q + (PW'(1) << (COEFQ - 1));
`ifdef GAIN_SAT_EN
    rsel_w = (DW + 1)'(rnd_w >> COEFQ);
    ovf_w  = rsel_w[DW] ^ rsel_w[DW-1];
    if (ovf_w) res_w = rsel_w[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else       res_w = rsel_w[DW-1:0];
    sat_d  = sat_q | (o_load & ovf_w);
`else
    res_w = DW'(rnd_w >> COEFQ);
`endif
    o_vld_d  = o_adv ? m_vld_q : o_vld_q;
    o_dat_d  = o_load ? res_w : o_dat_q;
    o_last_d = o_load ? m_last_q : o_last_q;
  end

  // one ramp step per frame, taken as the tlast beat enters stage M
  always_comb begin
    kt_x    = AW'($signed(k_target));
    kc_x    = AW'($signed(kc_q));
    st_x    = AW'(k_step);
    diff_w  = kt_x - kc_x;
    adiff_w = diff_w[AW-1] ? (AW'(0) - diff_w) : diff_w;
    if (k_step == '0 || adiff_w <= st_x) nxt_w = kt_x;
    else if (diff_w[AW-1])                 nxt_w = kc_x - st_x;
    else                                   nxt_w = kc_x + st_x;
    kc_d = kc_q;
    kt_d = kt_q;
    if (sk_pop && sk_head[DW]) begin
      kc_d = COEFW'(nxt_w);
      kt_d = k_target;
    end
  end

  // a missing tlast parks the counter at the last channel until a tlast resyncs it
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (sk_pop) begin
      if (sk_head[DW]) begin
        err_d = (cnt_q != LAST_CH);
        cnt_d = '0;
      end else if (cnt_q == LAST_CH) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_mem_q[0] <= '0;
      sk_mem_q[1] <= '0;
      sk_wp_q     <= 1'b0;
      sk_rp_q     <= 1'b0;
      sk_cnt_q    <= 2'd0;
      sk_rdy_q    <= 1'b0;
      m_vld_q     <= 1'b0;
      m_last_q    <= 1'b0;
      m_prod_q    <= '0;
      o_vld_q     <= 1'b0;
      o_last_q    <= 1'b0;
      o_dat_q     <= '0;
      kc_q        <= '0;
      kt_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
`ifdef GAIN_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      sk_mem_q    <= sk_mem_d;
      sk_wp_q     <= sk_wp_d;
      sk_rp_q     <= sk_rp_d;
      sk_cnt_q    <= sk_cnt_d;
      sk_rdy_q    <= sk_rdy_d;
      m_vld_q     <= m_vld_d;
      m_last_q    <= m_last_d;
      m_prod_q    <= m_prod_d;
      o_vld_q     <= o_vld_d;
      o_last_q    <= o_last_d;
      o_dat_q     <= o_dat_d;
      kc_q        <= kc_d;
      kt_q        <= kt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`ifdef GAIN_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign s_axis_tready = sk_rdy_q;
  assign m_axis_tvalid = o_vld_q;
  assign m_axis_tdata  = o_dat_q;
  assign m_axis_tlast  = o_last_q;
  assign k_current     = kc_q;
  assign ramping       = (kc_q != kt_q);
  assign frame_err     = err_q;
`ifdef GAIN_SAT_EN
  assign sat_flag      = sat_q;
`endif

endmodule

// File: tb/tb_gain_ramp.sv
// Bench for gain_ramp: queue-based frame/gain model checked every output beat, plus hand-computed pins.
module tb_gain_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [19:0] k_target;
  logic [15:0] k_step;
  logic [19:0] k_current;
  logic        ramping;
  logic        frame_err;
`ifdef GAIN_SAT_EN
  logic        sat_flag;
`endif

  gain_ramp #(.DW(24), .COEFW(20), .COEFQ(16), .CH(2), .STEPW(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .k_target(k_target), .k_step(k_step), .k_current(k_current),
    .ramping(ramping),
`ifdef GAIN_SAT_EN
    .sat_flag(sat_flag),
`endif
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [24:0] exp_q[$];
  logic [23:0] out_log[$];
  longint      kc_m = 0;
  longint      kt_m = 0;
  int          cnt_m = 0;
  int          err_m = 0;
  bit          sat_m = 1'b0;
  int          n_out = 0;
  int          err_seen = 0;
  int          rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_out(input logic [23:0] x, input longint k);
    longint p, r;
    logic [63:0] rv;
    logic signed [24:0] r25;
    p  = longint'($signed(x)) * k + 64'sd32768;
    r  = p >>> 16;
    rv = r;
    r25 = rv[24:0];
`ifdef GAIN_SAT_EN
    if (r25 > 25'sd8388607)  begin sat_m = 1'b1; return 24'h7FFFFF; end
    if (r25 < -25'sd8388608) begin sat_m = 1'b1; return 24'h800000; end
`endif
    return rv[23:0];
  endfunction

  function automatic longint ramp_next(input longint kc, input longint kt, input longint st);
    longint d, ad;
    d  = kt - kc;
    ad = (d < 0) ? -d : d;
    if (st == 0 || ad <= st) return kt;
    return (d > 0) ? kc + st : kc - st;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    kc_m  = 0;
    kt_m  = 0;
    cnt_m = 0;
  endtask

  task automatic send(input logic [23:0] d, input logic l);
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      check("send_timeout", 64'(n), 64'(0));
      s_axis_tvalid = 1'b0;
      return;
    end
    exp_q.push_back({l, model_out(d, kc_m)});
    if (l) begin
      if (cnt_m != 1) err_m++;
      cnt_m = 0;
      kc_m  = ramp_next(kc_m, longint'($signed(k_target)), longint'(k_step));
      kt_m  = longint'($signed(k_target));
    end else if (cnt_m == 1) begin
      err_m++;
    end else begin
      cnt_m++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // output compare and hold-while-stalled check
  initial begin
    bit          stall_prev;
    logic [24:0] prev_word;
    logic [24:0] w;
    stall_prev = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_vld", 64'(m_axis_tvalid), 64'(1));
          check("hold_dat", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_word));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got %0h with no beat expected", m_axis_tdata);
          end else begin
            w = exp_q.pop_front();
            check("out_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(w));
            out_log.push_back(m_axis_tdata);
            n_out++;
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_word  = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && frame_err) err_seen++;
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  initial begin
    int e0, o0;
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    k_target = 20'h10000; k_step = 16'h4000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_vld",  64'(m_axis_tvalid), 64'(0));
    check("rst_m_dat",  64'(m_axis_tdata),  64'(0));
    check("rst_m_last", 64'(m_axis_tlast),  64'(0));
    check("rst_s_rdy",  64'(s_axis_tready), 64'(0));
    check("rst_kcur",   64'(k_current),     64'(0));
    check("rst_ramp",   64'(ramping),       64'(0));
    check("rst_ferr",   64'(frame_err),     64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", 64'(s_axis_tready), 64'(1));

    // ramp 0 -> 1.0 in steps of 0.25
    out_log.delete();
    for (int f = 0; f < 3; f++) begin send(24'h100000, 1'b0); send(24'h100000, 1'b1); end
    drain();
    check("mid_ramp_k",    64'(k_current), 64'(20'h0C000));
    check("mid_ramp_flag", 64'(ramping),   64'(1));
    for (int f = 0; f < 3; f++) begin send(24'h100000, 1'b0); send(24'h100000, 1'b1); end
    drain();
    check("ramp_log_size", 64'(out_log.size()), 64'(12));
    if (out_log.size() == 12) begin
      check("ramp_f0", 64'(out_log[0]),  64'(24'h000000));
      check("ramp_f1", 64'(out_log[2]),  64'(24'h040000));
      check("ramp_f2", 64'(out_log[4]),  64'(24'h080000));
      check("ramp_f3", 64'(out_log[6]),  64'(24'h0C0000));
      check("ramp_f4", 64'(out_log[8]),  64'(24'h100000));
      check("ramp_f5", 64'(out_log[11]), 64'(24'h100000));
    end
    check("ramp_done_flag", 64'(ramping),   64'(0));
    check("ramp_done_k",    64'(k_current), 64'(20'h10000));

    // jump to 0.5 and check half-up rounding
    k_step = 16'h0; k_target = 20'h08000;
    send(24'h0, 1'b0); send(24'h0, 1'b1);
    drain();
    check("jump_k", 64'(k_current), 64'(20'h08000));
    out_log.delete();
    send(24'h000003, 1'b0); send(24'hFFFFFD, 1'b1);
    drain();
    if (out_log.size() == 2) begin
      check("round_pos", 64'(out_log[0]), 64'(24'h000002));
      check("round_neg", 64'(out_log[1]), 64'(24'hFFFFFF));
    end else check("round_log_size", 64'(out_log.size()), 64'(2));

    // gain 2.0 overflows
    k_target = 20'h20000;
    send(24'h0, 1'b0); send(24'h0, 1'b1);
    drain();
    out_log.delete();
    send(24'h500000, 1'b0); send(24'h0, 1'b1);
    drain();
`ifdef GAIN_SAT_EN
    if (out_log.size() == 2) check("sat_value", 64'(out_log[0]), 64'(24'h7FFFFF));
    check("sat_flag", 64'(sat_flag), 64'(1));
`else
    if (out_log.size() == 2) check("wrap_value", 64'(out_log[0]), 64'(24'hA00000));
`endif

    // 1000 beats with random downstream stalls while ramping 2.0 -> 1.0
    k_target = 20'h10000; k_step = 16'h1000;
    e0 = err_seen; o0 = n_out;
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) send(24'($urandom), 1'(i % 2));
    rdy_mode = 0;
    drain();
    check("stall_beats", 64'(n_out - o0),    64'(1000));
    check("stall_no_err", 64'(err_seen - e0), 64'(0));
    check("stall_k",      64'(k_current),     64'(kc_m[19:0]));
`ifdef GAIN_SAT_EN
    check("sat_sticky", 64'(sat_flag), 64'(sat_m));
`endif

    // framing: tlast on channel 0, then a good frame
    k_step = 16'h0; k_target = 20'h18000;
    e0 = err_seen;
    send(24'h000100, 1'b1);
    drain();
    check("short_err",  64'(err_seen - e0), 64'(1));
    check("short_k",    64'(k_current),     64'(20'h18000));
    k_target = 20'h06000;
    send(24'h000200, 1'b0); send(24'h000300, 1'b1);
    drain();
    check("good_no_err", 64'(err_seen - e0), 64'(1));
    check("good_k",      64'(k_current),     64'(20'h06000));
    check("err_model",   64'(err_seen),      64'(err_m));

    // reset mid-ramp with the output stalled
    k_target = 20'h10000; k_step = 16'h0100;
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(24'h001000 + 24'(i), 1'(i % 2));
    check("pre_rst_ramp", 64'(ramping), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_vld",  64'(m_axis_tvalid), 64'(0));
    check("mid_rst_k",    64'(k_current),     64'(0));
    check("mid_rst_ramp", 64'(ramping),       64'(0));
    model_reset();
    rdy_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("resume_rdy", 64'(s_axis_tready), 64'(1));
    send(24'h010000, 1'b0); send(24'h020000, 1'b1);
    send(24'h030000, 1'b0); send(24'h040000, 1'b1);
    drain();
    check("resume_k", 64'(k_current), 64'(kc_m[19:0]));
    check("resume_k_lit", 64'(k_current), 64'(20'h00200));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
